// File: rtl/reversi_move_sequencer.sv
// reversi_move_sequencer: owns the 64-cell Reversi board and sequences a
// move one cell per cycle: target check, 8-direction scan, flip, commit.
//
// Ports: clk, resetn (synchronous, active high), x/y/go/pass (move
// request, sampled in IDLE), busy, done (1-cycle pulse), move_ok,
// black_turn, board_result (cell p = y*8+x at bits [3p+2:3p]).
// Optional: define REVERSI_FLIP_COUNT_EN to add flip_count[5:0].
module reversi_move_sequencer #(
    parameter bit BLACK_FIRST = 1'b1,
    parameter bit CLEAR_HINTS = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [2:0]   x,
    input  logic [2:0]   y,
    input  logic         go,
    input  logic         pass,
    output logic         busy,
    output logic         done,
    output logic         move_ok,
    output logic         black_turn,
`ifdef REVERSI_FLIP_COUNT_EN
    output logic [5:0]   flip_count,
`endif
    output logic [191:0] board_result
);

    localparam logic [2:0] EMPTY = 3'b000;
    localparam logic [2:0] HINT  = 3'b100;

    localparam logic [191:0] INIT_BOARD =
        (192'(3'b110) << 81) | (192'(3'b111) << 84) |
        (192'(3'b111) << 105) | (192'(3'b110) << 108);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SCAN, S_FLIP, S_NEXTDIR, S_COMMIT
    } state_t;

    state_t state_q, state_d;

    // committed board and the working copy that collects flips
    logic [2:0] board_c  [64];
    logic [2:0] work_c   [64];
    logic [2:0] commit_c [64];

    logic [2:0] tx_q, ty_q;
    logic [2:0] cx_q, cy_q;
    logic [2:0] dir_q;
    logic [2:0] run_q;
    logic       ply_q;
    logic       any_flip_q;
    logic       done_q;
    logic       ok_q;
    logic       turn_q;
`ifdef REVERSI_FLIP_COUNT_EN
    logic [5:0] flips_q;
    logic [5:0] fcnt_q;
`endif

    logic [3:0] dx, dy;
    logic [3:0] nx, ny;
    logic       off_board;
    logic [5:0] nidx, tidx, cidx;
    logic [2:0] ncell, tcell;
    logic [2:0] own, opp;

    assign own  = {2'b11, ply_q};
    assign opp  = {2'b11, ~ply_q};
    assign tidx = {ty_q, tx_q};
    assign cidx = {cy_q, cx_q};

    // 4-bit two's complement deltas: 0001 = +1, 1111 = -1
    always_comb begin
        dx = 4'b0000;
        dy = 4'b0000;
        unique case (dir_q)
            3'd0: begin dx = 4'b0001; dy = 4'b0000; end
            3'd1: begin dx = 4'b1111; dy = 4'b0000; end
            3'd2: begin dx = 4'b0000; dy = 4'b0001; end
            3'd3: begin dx = 4'b0000; dy = 4'b1111; end
            3'd4: begin dx = 4'b0001; dy = 4'b0001; end
            3'd5: begin dx = 4'b1111; dy = 4'b0001; end
            3'd6: begin dx = 4'b0001; dy = 4'b1111; end
            3'd7: begin dx = 4'b1111; dy = 4'b1111; end
        endcase
    end

    // stepping off either edge lands on -1 or 8, both with bit 3 set
    assign nx        = {1'b0, cx_q} + dx;
    assign ny        = {1'b0, cy_q} + dy;
    assign off_board = nx[3] | ny[3];
    assign nidx      = {ny[2:0], nx[2:0]};
    assign ncell     = board_c[nidx];
    assign tcell     = board_c[tidx];

    always_comb begin
        for (int i = 0; i < 64; i++) begin
            commit_c[i] = work_c[i];
            if (CLEAR_HINTS && work_c[i] == HINT)
                commit_c[i] = EMPTY;
            if (6'(i) == tidx)
                commit_c[i] = own;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (go)
                    state_d = S_CHECK;
            S_CHECK:
                if (tcell[2:1] == 2'b11)
                    state_d = S_COMMIT;
                else
                    state_d = S_SCAN;
            S_SCAN:
                if (off_board)
                    state_d = S_NEXTDIR;
                else if (ncell == opp)
                    state_d = S_SCAN;
                else if (ncell == own && run_q != 3'd0)
                    state_d = S_FLIP;
                else
                    state_d = S_NEXTDIR;
            S_FLIP:
                if (run_q == 3'd1)
                    state_d = S_NEXTDIR;
            S_NEXTDIR:
                if (dir_q == 3'd7)
                    state_d = S_COMMIT;
                else
                    state_d = S_SCAN;
            S_COMMIT:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 64; i++)
                board_c[i] <= INIT_BOARD[3*i +: 3];
            tx_q       <= 3'd0;
            ty_q       <= 3'd0;
            cx_q       <= 3'd0;
            cy_q       <= 3'd0;
            dir_q      <= 3'd0;
            run_q      <= 3'd0;
            ply_q      <= 1'b0;
            any_flip_q <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            turn_q     <= BLACK_FIRST;
`ifdef REVERSI_FLIP_COUNT_EN
            flips_q    <= 6'd0;
            fcnt_q     <= 6'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        tx_q   <= x;
                        ty_q   <= y;
                        cx_q   <= x;
                        cy_q   <= y;
                        ply_q  <= turn_q;
                        work_c <= board_c;
                    end else if (pass) begin
                        turn_q <= ~turn_q;
                    end
                end
                S_CHECK: begin
                    dir_q      <= 3'd0;
                    run_q      <= 3'd0;
                    any_flip_q <= 1'b0;
`ifdef REVERSI_FLIP_COUNT_EN
                    flips_q    <= 6'd0;
`endif
                end
                S_SCAN: begin
                    if (!off_board && ncell == opp) begin
                        cx_q  <= nx[2:0];
                        cy_q  <= ny[2:0];
                        run_q <= run_q + 3'd1;
                    end
                end
                S_FLIP: begin
                    work_c[cidx] <= own;
                    cx_q         <= 3'({1'b0, cx_q} - dx);
                    cy_q         <= 3'({1'b0, cy_q} - dy);
                    run_q        <= run_q - 3'd1;
                    any_flip_q   <= 1'b1;
`ifdef REVERSI_FLIP_COUNT_EN
                    flips_q      <= flips_q + 6'd1;
`endif
                end
                S_NEXTDIR: begin
                    dir_q <= dir_q + 3'd1;
                    cx_q  <= tx_q;
                    cy_q  <= ty_q;
                    run_q <= 3'd0;
                end
                S_COMMIT: begin
                    done_q <= 1'b1;
                    ok_q   <= any_flip_q;
`ifdef REVERSI_FLIP_COUNT_EN
                    fcnt_q <= any_flip_q ? flips_q : 6'd0;
`endif
                    if (any_flip_q) begin
                        board_c <= commit_c;
                        turn_q  <= ~turn_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done       = done_q;
    assign move_ok    = ok_q;
    assign black_turn = turn_q;
`ifdef REVERSI_FLIP_COUNT_EN
    assign flip_count = fcnt_q;
`endif

    for (genvar g = 0; g < 64; g++) begin : g_pack
        assign board_result[3*g +: 3] = board_c[g];
    end

endmodule

// File: tb/tb_reversi_move_sequencer.sv
// tb_reversi_move_sequencer: directed bench for reversi_move_sequencer.
// Each scenario task drives a move and checks results inline.
module tb_reversi_move_sequencer;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [2:0]   x = 3'd0;
    logic [2:0]   y = 3'd0;
    logic         go = 1'b0;
    logic         pass = 1'b0;
    logic         busy;
    logic         done;
    logic         move_ok;
    logic         black_turn;
    logic [191:0] board_result;
`ifdef REVERSI_FLIP_COUNT_EN
    logic [5:0]   flip_count;
`endif

    int checks = 0;
    int fails  = 0;

    localparam logic [191:0] INIT =
        (192'(3'b110) << 81) | (192'(3'b111) << 84) |
        (192'(3'b111) << 105) | (192'(3'b110) << 108);

    logic [191:0] exp_legal;
    logic [191:0] exp_white;

    reversi_move_sequencer dut (
        .clk(clk),
        .resetn(resetn),
        .x(x),
        .y(y),
        .go(go),
        .pass(pass),
        .busy(busy),
        .done(done),
        .move_ok(move_ok),
        .black_turn(black_turn),
`ifdef REVERSI_FLIP_COUNT_EN
        .flip_count(flip_count),
`endif
        .board_result(board_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [191:0] put(input logic [191:0] b,
                                         input int p,
                                         input logic [2:0] c);
        logic [191:0] r;
        r = b;
        r[3*p +: 3] = c;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        go     = 1'b0;
        pass   = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
    endtask

    task automatic start_move(input logic [2:0] mx, input logic [2:0] my);
        x  = mx;
        y  = my;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 150) begin
            tick();
            n++;
            if (done === 1'b1)
                break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (board_result !== INIT) begin
            fails++;
            $display("FAIL reset_board got %h want %h", board_result, INIT);
        end
        checks++;
        if (black_turn !== 1'b1) begin
            fails++;
            $display("FAIL reset_turn got %b want 1", black_turn);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || move_ok !== 1'b0) begin
            fails++;
            $display("FAIL reset_status busy/done/ok got %b%b%b want 000",
                     busy, done, move_ok);
        end
`ifdef REVERSI_FLIP_COUNT_EN
        checks++;
        if (flip_count !== 6'd0) begin
            fails++;
            $display("FAIL reset_flip_count got %0d want 0", flip_count);
        end
`endif
    endtask

    task automatic test_legal();
        int n;
        start_move(3'd2, 3'd3);
        wait_done(n);
        checks++;
        if (done !== 1'b1 || n > 115) begin
            fails++;
            $display("FAIL legal_latency got %0d cycles want <=115", n);
        end
        checks++;
        if (move_ok !== 1'b1) begin
            fails++;
            $display("FAIL legal_ok got %b want 1", move_ok);
        end
        checks++;
        if (board_result !== exp_legal) begin
            fails++;
            $display("FAIL legal_board got %h want %h",
                     board_result, exp_legal);
        end
        checks++;
        if (black_turn !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL legal_turn turn/busy got %b%b want 00",
                     black_turn, busy);
        end
`ifdef REVERSI_FLIP_COUNT_EN
        checks++;
        if (flip_count !== 6'd1) begin
            fails++;
            $display("FAIL legal_flip_count got %0d want 1", flip_count);
        end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || move_ok !== 1'b1) begin
            fails++;
            $display("FAIL legal_pulse done/ok got %b%b want 01",
                     done, move_ok);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_move(3'd2, 3'd2);
        wait_done(n);
        checks++;
        if (done !== 1'b1 || move_ok !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ok done/ok got %b%b want 11", done, move_ok);
        end
        checks++;
        if (board_result !== exp_white) begin
            fails++;
            $display("FAIL b2b_board got %h want %h",
                     board_result, exp_white);
        end
        checks++;
        if (black_turn !== 1'b1) begin
            fails++;
            $display("FAIL b2b_turn got %b want 1", black_turn);
        end
`ifdef REVERSI_FLIP_COUNT_EN
        checks++;
        if (flip_count !== 6'd1) begin
            fails++;
            $display("FAIL b2b_flip_count got %0d want 1", flip_count);
        end
`endif
    endtask

    task automatic test_occupied();
        do_reset();
        start_move(3'd3, 3'd3);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL occ_cycle0 busy/done got %b%b want 10",
                     busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL occ_cycle1 done got %b want 0", done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || move_ok !== 1'b0) begin
            fails++;
            $display("FAIL occ_cycle2 done/busy/ok got %b%b%b want 100",
                     done, busy, move_ok);
        end
        checks++;
        if (board_result !== INIT || black_turn !== 1'b1) begin
            fails++;
            $display("FAIL occ_board turn=%b board %h want 1 %h",
                     black_turn, board_result, INIT);
        end
    endtask

    task automatic test_no_flip();
        int n;
        do_reset();
        start_move(3'd0, 3'd0);
        wait_done(n);
        checks++;
        if (done !== 1'b1 || n > 115) begin
            fails++;
            $display("FAIL noflip_latency got %0d cycles want <=115", n);
        end
        checks++;
        if (move_ok !== 1'b0) begin
            fails++;
            $display("FAIL noflip_ok got %b want 0", move_ok);
        end
        checks++;
        if (board_result !== INIT || black_turn !== 1'b1) begin
            fails++;
            $display("FAIL noflip_board turn=%b board %h want 1 %h",
                     black_turn, board_result, INIT);
        end
`ifdef REVERSI_FLIP_COUNT_EN
        checks++;
        if (flip_count !== 6'd0) begin
            fails++;
            $display("FAIL noflip_flip_count got %0d want 0", flip_count);
        end
`endif
    endtask

    task automatic test_busy_ignore();
        int n;
        do_reset();
        start_move(3'd2, 3'd3);
        x    = 3'd0;
        y    = 3'd0;
        go   = 1'b1;
        pass = 1'b1;
        tick();
        tick();
        tick();
        go   = 1'b0;
        pass = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || move_ok !== 1'b1) begin
            fails++;
            $display("FAIL busy_ign_ok done/ok got %b%b want 11",
                     done, move_ok);
        end
        checks++;
        if (board_result !== exp_legal || black_turn !== 1'b0) begin
            fails++;
            $display("FAIL busy_ign_board turn=%b board %h want 0 %h",
                     black_turn, board_result, exp_legal);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_ign_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_pass();
        do_reset();
        pass = 1'b1;
        tick();
        pass = 1'b0;
        checks++;
        if (black_turn !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pass_once turn/busy got %b%b want 00",
                     black_turn, busy);
        end
        pass = 1'b1;
        tick();
        pass = 1'b0;
        checks++;
        if (black_turn !== 1'b1) begin
            fails++;
            $display("FAIL pass_twice turn got %b want 1", black_turn);
        end
    endtask

    task automatic test_go_pass();
        int n;
        do_reset();
        x    = 3'd2;
        y    = 3'd3;
        go   = 1'b1;
        pass = 1'b1;
        tick();
        go   = 1'b0;
        pass = 1'b0;
        checks++;
        if (busy !== 1'b1 || black_turn !== 1'b1) begin
            fails++;
            $display("FAIL gopass_start busy/turn got %b%b want 11",
                     busy, black_turn);
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1 || move_ok !== 1'b1) begin
            fails++;
            $display("FAIL gopass_ok done/ok got %b%b want 11",
                     done, move_ok);
        end
        checks++;
        if (board_result !== exp_legal || black_turn !== 1'b0) begin
            fails++;
            $display("FAIL gopass_board turn=%b board %h want 0 %h",
                     black_turn, board_result, exp_legal);
        end
    endtask

    task automatic test_reset_flip();
        int seen;
        do_reset();
        start_move(3'd2, 3'd3);
        tick();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (board_result !== INIT) begin
            fails++;
            $display("FAIL rstflip_board got %h want %h",
                     board_result, INIT);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || black_turn !== 1'b1) begin
            fails++;
            $display("FAIL rstflip_status busy/done/turn got %b%b%b want 001",
                     busy, done, black_turn);
        end
        resetn = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1)
                seen++;
        end
        checks++;
        if (seen != 0 || board_result !== INIT) begin
            fails++;
            $display("FAIL rstflip_quiet got %0d busy/done cycles want 0",
                     seen);
        end
    endtask

    initial begin
        exp_legal = put(put(INIT, 26, 3'b111), 27, 3'b111);
        exp_white = put(put(exp_legal, 18, 3'b110), 27, 3'b110);
        test_reset();
        test_legal();
        test_back_to_back();
        test_occupied();
        test_no_flip();
        test_busy_ignore();
        test_pass();
        test_go_pass();
        test_reset_flip();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
